itag_flush_ctl: RTL and testbench
=================================

ITAG_FLUSH_CTL -- requirements
Module: itag_flush_ctl

Interface
REQ-001 The block SHALL have parameter IDX_W, default 10, giving the tag-array index width (icu_tag_addr[`ic_msb:4]).
REQ-002 The block SHALL have parameter TAG_W, default 18, giving the tag address-field width (icu_tag_in[`it_msb:0]).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 The block SHALL have port reset_l, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port flush_req, input, 1 bit: single-cycle pulse requesting invalidate-all.
REQ-006 The block SHALL have port flush_busy, output, 1 bit: high while a sweep is in progress.
REQ-007 The block SHALL have port flush_done, output, 1 bit: one-cycle pulse when a sweep completes.
REQ-008 The block SHALL have port fill_req, input, 1 bit: line-fill tag write request, held high until acknowledged.
REQ-009 The block SHALL have port fill_idx, input, IDX_W bits: index for the fill.
REQ-010 The block SHALL have port fill_tag, input, TAG_W bits: tag written by the fill, with the valid bit set.
REQ-011 The block SHALL have port fill_ack, output, 1 bit: high in the cycle the fill write is issued.
REQ-012 The block SHALL have port lkp_req, input, 1 bit: lookup request, held high until granted.
REQ-013 The block SHALL have port lkp_idx, input, IDX_W bits: index for the lookup.
REQ-014 The block SHALL have port lkp_gnt, output, 1 bit: high in the cycle the lookup read is issued.
REQ-015 The block SHALL have port lkp_rsp_vld, output, 1 bit: high one cycle after lkp_gnt.
REQ-016 The block SHALL have port lkp_hit, output, 1 bit: lookup result, meaningful only when lkp_rsp_vld is high.
REQ-017 The block SHALL have port ic_hit, input, 1 bit: hit indication from the tag array.
REQ-018 The block SHALL have port itag_vld, input, 1 bit: valid bit read from the tag array.
REQ-019 The block SHALL have port icu_tag_addr, output, IDX_W bits: tag-array index.
REQ-020 The block SHALL have port icu_tag_in, output, TAG_W bits: tag-array write data.
REQ-021 The block SHALL have port icu_tag_vld, output, 1 bit: valid bit written to the tag array.
REQ-022 The block SHALL have port icu_tag_we, output, 1 bit: tag-array write enable.
REQ-023 The block SHALL have port enable, output, 1 bit: tag-array enable; low means power-down.

Function
REQ-024 FSM states SHALL be FLUSH, DONE and IDLE. FLUSH goes to DONE when idx_cnt reaches 2^IDX_W-1. DONE goes to IDLE after one cycle. IDLE goes to FLUSH on flush_req.
REQ-025 In FLUSH, each cycle SHALL drive icu_tag_we=1, icu_tag_vld=0, icu_tag_in=0 and icu_tag_addr=idx_cnt, then increment idx_cnt.
REQ-026 idx_cnt SHALL wrap from 2^IDX_W-1 to 0; a sweep lasts exactly 2^IDX_W cycles.
REQ-027 flush_busy SHALL equal (state==FLUSH); flush_done SHALL equal (state==DONE).
REQ-028 flush_req during FLUSH or DONE SHALL be ignored, with no restart and no extension of the sweep.
REQ-029 In IDLE, a fill SHALL take priority over a lookup. With fill_req=1, fill_ack, icu_tag_we and icu_tag_vld SHALL be 1, icu_tag_addr SHALL equal fill_idx, icu_tag_in SHALL equal fill_tag, and lkp_gnt SHALL be 0.
REQ-030 In IDLE with fill_req=0 and lkp_req=1, lkp_gnt SHALL be 1, icu_tag_we SHALL be 0 and icu_tag_addr SHALL equal lkp_idx.
REQ-031 lkp_rsp_vld SHALL be a registered copy of lkp_gnt; lkp_hit SHALL equal ic_hit & itag_vld in that cycle.
REQ-032 flush_req together with fill_req in IDLE: the fill SHALL be serviced that cycle and FLUSH entered next cycle.
REQ-033 fill_ack and lkp_gnt SHALL be 0 in FLUSH and DONE; held requests SHALL be serviced once the FSM is back in IDLE.
REQ-034 enable SHALL be 1 when state!=IDLE, fill_ack=1 or lkp_gnt=1; otherwise it SHALL be 0.
REQ-035 When nothing is issued, icu_tag_addr SHALL hold its previous value and icu_tag_we SHALL be 0.

Reset
REQ-036 While reset_l=0, state SHALL be FLUSH, idx_cnt 0, flush_busy 1, and flush_done, fill_ack, lkp_gnt, lkp_rsp_vld, lkp_hit, icu_tag_we, icu_tag_vld, icu_tag_in and icu_tag_addr all 0; enable SHALL be 1.
REQ-037 After reset deassertion, an automatic power-on sweep SHALL begin on the first clock edge.
REQ-038 Reset asserted mid-sweep SHALL restart the sweep from index 0 after deassertion, and no flush_done SHALL be produced for the aborted sweep.

Structure
REQ-039 State encodings (FLUSH=2'b00, DONE=2'b01, IDLE=2'b10) and the index/tag widths SHALL live in the shared defines.h.
REQ-040 The index counter SHALL be a sub-module itag_sweep_cnt (clear, increment, last flag).

Verification
REQ-041 Bench SHALL use IDX_W=3. Reset release -> 8 writes with icu_tag_vld=0 at indices 0..7, then flush_done at cycle 9, then IDLE.
REQ-042 In IDLE, fill_req=1, fill_idx=5, fill_tag=18'h2A5A5 -> same-cycle fill_ack=1, icu_tag_we=1, icu_tag_addr=5, icu_tag_vld=1.
REQ-043 fill_req and lkp_req both held for 2 cycles, fill dropped after ack -> cycle 1 fill_ack=1; cycle 2 lkp_gnt=1; cycle 3 lkp_rsp_vld=1 with lkp_hit = ic_hit & itag_vld.
REQ-044 flush_req at sweep index 3 -> ignored; flush_done exactly 8 cycles after sweep start.
REQ-045 reset_l=0 at sweep index 6, released 2 cycles later -> sweep restarts at index 0, and exactly one flush_done follows 8 cycles later.
REQ-046 lkp_req held throughout a sweep -> lkp_gnt=0 until the cycle after flush_done, then 1.

Source files
------------

// File: rtl/itag_flush_ctl_pkg.sv
// Shared types and default widths for the instruction-tag flush controller.
package itag_flush_ctl_pkg;

  localparam int IDX_W_DEF = 10;
  localparam int TAG_W_DEF = 18;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'b00,
    ST_DONE  = 2'b01,
    ST_IDLE  = 2'b10
  } fsm_state_e;

endpackage

// File: rtl/itag_sweep_cnt.sv
// Sweep index counter: clears, increments, and flags the last index of the tag array.
module itag_sweep_cnt #(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             clr,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l)  idx <= '0;
    else if (clr)  idx <= '0;
    else if (inc)  idx <= idx + ONE;
  end

  assign last = &idx;

endmodule

// File: rtl/itag_flush_ctl.sv
// Tag-array controller: invalidate-all sweep on reset or request, plus fill/lookup arbitration in idle.
module itag_flush_ctl
  import itag_flush_ctl_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic             flush_done,
  input  logic             fill_req,
  input  logic [IDX_W-1:0] fill_idx,
  input  logic [TAG_W-1:0] fill_tag,
  output logic             fill_ack,
  input  logic             lkp_req,
  input  logic [IDX_W-1:0] lkp_idx,
  output logic             lkp_gnt,
  output logic             lkp_rsp_vld,
  output logic             lkp_hit,
  input  logic             ic_hit,
  input  logic             itag_vld,
  output logic [IDX_W-1:0] icu_tag_addr,
  output logic [TAG_W-1:0] icu_tag_in,
  output logic             icu_tag_vld,
  output logic             icu_tag_we,
  output logic             enable
);

  fsm_state_e       state, state_nxt;
  logic [IDX_W-1:0] idx_cnt;
  logic             idx_last;
  logic [IDX_W-1:0] addr_q;

  itag_sweep_cnt #(.IDX_W(IDX_W)) u_sweep_cnt (
    .clk     (clk),
    .reset_l (reset_l),
    .clr     (state != ST_FLUSH),
    .inc     (state == ST_FLUSH),
    .idx     (idx_cnt),
    .last    (idx_last)
  );

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state <= ST_FLUSH;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FLUSH: if (idx_last)  state_nxt = ST_DONE;
      ST_DONE:                 state_nxt = ST_IDLE;
      ST_IDLE:  if (flush_req) state_nxt = ST_FLUSH;
      default:                 state_nxt = ST_FLUSH;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    fill_ack     = 1'b0;
    lkp_gnt      = 1'b0;
    icu_tag_we   = 1'b0;
    icu_tag_vld  = 1'b0;
    icu_tag_in   = '0;
    icu_tag_addr = addr_q;
    case (state)
      ST_FLUSH: begin
        // Reset parks the FSM in FLUSH; suppress the write until reset is released.
        if (reset_l) begin
          icu_tag_we   = 1'b1;
          icu_tag_addr = idx_cnt;
        end
      end
      ST_IDLE: begin
        if (fill_req) begin
          fill_ack     = 1'b1;
          icu_tag_we   = 1'b1;
          icu_tag_vld  = 1'b1;
          icu_tag_addr = fill_idx;
          icu_tag_in   = fill_tag;
        end else if (lkp_req) begin
          lkp_gnt      = 1'b1;
          icu_tag_addr = lkp_idx;
        end
      end
      default: ;
    endcase
  end

  assign flush_busy = (state == ST_FLUSH);
  assign flush_done = (state == ST_DONE);
  assign enable     = (state != ST_IDLE) | fill_ack | lkp_gnt;

  // Tag-array address holds the last issued index while nothing is issued.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      addr_q      <= '0;
      lkp_rsp_vld <= 1'b0;
    end else begin
      if (icu_tag_we | lkp_gnt) addr_q <= icu_tag_addr;
      lkp_rsp_vld <= lkp_gnt;
    end
  end

  assign lkp_hit = lkp_rsp_vld & ic_hit & itag_vld;

endmodule

// File: tb/tb_itag_flush_ctl.sv
// Self-checking bench for itag_flush_ctl: directed scenarios then randomized traffic against a behavioural model.
module tb_itag_flush_ctl;

  localparam int IDX_W = 3;
  localparam int TAG_W = 18;
  localparam int N     = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             reset_l = 1'b0;
  logic             flush_req = 1'b0;
  logic             fill_req = 1'b0;
  logic [IDX_W-1:0] fill_idx = '0;
  logic [TAG_W-1:0] fill_tag = '0;
  logic             lkp_req = 1'b0;
  logic [IDX_W-1:0] lkp_idx = '0;
  logic             ic_hit = 1'b0;
  logic             itag_vld = 1'b0;
  logic             flush_busy, flush_done, fill_ack, lkp_gnt, lkp_rsp_vld, lkp_hit;
  logic [IDX_W-1:0] icu_tag_addr;
  logic [TAG_W-1:0] icu_tag_in;
  logic             icu_tag_vld, icu_tag_we, enable;

  itag_flush_ctl #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .reset_l      (reset_l),
    .flush_req    (flush_req),
    .flush_busy   (flush_busy),
    .flush_done   (flush_done),
    .fill_req     (fill_req),
    .fill_idx     (fill_idx),
    .fill_tag     (fill_tag),
    .fill_ack     (fill_ack),
    .lkp_req      (lkp_req),
    .lkp_idx      (lkp_idx),
    .lkp_gnt      (lkp_gnt),
    .lkp_rsp_vld  (lkp_rsp_vld),
    .lkp_hit      (lkp_hit),
    .ic_hit       (ic_hit),
    .itag_vld     (itag_vld),
    .icu_tag_addr (icu_tag_addr),
    .icu_tag_in   (icu_tag_in),
    .icu_tag_vld  (icu_tag_vld),
    .icu_tag_we   (icu_tag_we),
    .enable       (enable)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_pulses = 0;

  // Model: writes remaining in the current sweep, a pending done pulse, last issued address.
  int m_left, m_done, m_last_addr, m_prev_gnt;
  int e_ack, e_gnt, e_we, e_vld, e_en, e_addr;
  logic [TAG_W-1:0] e_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_left      = N;
    m_done      = 0;
    m_last_addr = 0;
    m_prev_gnt  = 0;
  endtask

  task automatic cycle();
    @(negedge clk);
    e_ack = 0; e_gnt = 0; e_we = 0; e_vld = 0; e_en = 0; e_addr = m_last_addr; e_in = '0;
    if (!reset_l) begin
      check("rst_busy", flush_busy, 1);
      check("rst_done", flush_done, 0);
      check("rst_ack",  fill_ack, 0);
      check("rst_gnt",  lkp_gnt, 0);
      check("rst_rsp",  lkp_rsp_vld, 0);
      check("rst_hit",  lkp_hit, 0);
      check("rst_we",   icu_tag_we, 0);
      check("rst_vld",  icu_tag_vld, 0);
      check("rst_in",   icu_tag_in, 0);
      check("rst_addr", icu_tag_addr, 0);
      check("rst_en",   enable, 1);
    end else begin
      if (m_left > 0) begin
        e_we = 1; e_en = 1; e_addr = N - m_left;
      end else if (m_done != 0) begin
        e_en = 1;
      end else if (fill_req) begin
        e_ack = 1; e_we = 1; e_vld = 1; e_en = 1; e_addr = fill_idx; e_in = fill_tag;
      end else if (lkp_req) begin
        e_gnt = 1; e_en = 1; e_addr = lkp_idx;
      end
      check("busy",    flush_busy, (m_left > 0) ? 1 : 0);
      check("done",    flush_done, m_done);
      check("ack",     fill_ack, e_ack);
      check("gnt",     lkp_gnt, e_gnt);
      check("we",      icu_tag_we, e_we);
      check("addr",    icu_tag_addr, e_addr);
      check("enable",  enable, e_en);
      check("rsp_vld", lkp_rsp_vld, m_prev_gnt);
      check("hit",     lkp_hit, (m_prev_gnt != 0 && ic_hit && itag_vld) ? 1 : 0);
      if (e_we != 0) begin
        check("wr_vld", icu_tag_vld, e_vld);
        check("wr_in",  icu_tag_in, e_in);
      end
      if (flush_done) done_pulses++;
    end
    @(posedge clk);
    if (reset_l) begin
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_done = 1;
      end else if (m_done != 0) begin
        m_done = 0;
      end else if (flush_req) begin
        m_left = N;
      end
      if (e_we != 0 || e_gnt != 0) m_last_addr = e_addr;
      m_prev_gnt = e_gnt;
    end
    #1;
  endtask

  task automatic assert_reset();
    reset_l = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (3) cycle();
    reset_l = 1'b1;
    // Power-on sweep: 8 writes, done, then idle.
    repeat (11) cycle();

    // Directed fill.
    fill_req = 1'b1; fill_idx = 3'd5; fill_tag = 18'h2A5A5;
    cycle();
    fill_req = 1'b0;
    cycle();

    // Fill wins over a simultaneous lookup; lookup is granted next cycle.
    fill_req = 1'b1; fill_idx = 3'd2; fill_tag = 18'h1F00F;
    lkp_req = 1'b1; lkp_idx = 3'd6;
    cycle();
    fill_req = 1'b0;
    cycle();
    lkp_req = 1'b0; ic_hit = 1'b1; itag_vld = 1'b1;
    cycle();
    lkp_req = 1'b1; lkp_idx = 3'd1;
    cycle();
    lkp_req = 1'b0; ic_hit = 1'b1; itag_vld = 1'b0;
    cycle();

    // flush_req at sweep index 3 is ignored.
    flush_req = 1'b1; cycle(); flush_req = 1'b0;
    repeat (3) cycle();
    flush_req = 1'b1; cycle(); flush_req = 1'b0;
    repeat (8) cycle();

    // Reset at sweep index 6: restart and exactly one done pulse.
    flush_req = 1'b1; cycle(); flush_req = 1'b0;
    repeat (6) cycle();
    assert_reset();
    repeat (2) cycle();
    reset_l = 1'b1;
    done_pulses = 0;
    repeat (12) cycle();
    check("one_done_after_abort", done_pulses, 1);

    // Lookup held across a whole sweep.
    flush_req = 1'b1; cycle(); flush_req = 1'b0;
    lkp_req = 1'b1; lkp_idx = 3'd4;
    repeat (12) cycle();
    lkp_req = 1'b0;
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (fill_req && e_ack != 0) fill_req = 1'b0;
      if (lkp_req && e_gnt != 0) lkp_req = 1'b0;
      if (!fill_req && $urandom_range(0, 3) == 0) begin
        fill_req = 1'b1;
        fill_idx = IDX_W'($urandom);
        fill_tag = TAG_W'($urandom);
      end
      if (!lkp_req && $urandom_range(0, 2) == 0) begin
        lkp_req = 1'b1;
        lkp_idx = IDX_W'($urandom);
      end
      flush_req = ($urandom_range(0, 24) == 0);
      ic_hit    = 1'($urandom);
      itag_vld  = 1'($urandom);
      if (reset_l && $urandom_range(0, 299) == 0) assert_reset();
      else if (!reset_l && $urandom_range(0, 1) == 0) reset_l = 1'b1;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
